bus_timing: RTL and testbench



---
 rtl/bus_timing_pkg.sv | 41 ++++
 rtl/bus_timing.sv | 164 ++++++++++++++++
 tb/tb_bus_timing.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/bus_timing_pkg.sv
// Shared definitions for the 8085 machine-cycle / T-state sequencer:
// decoded-instruction field positions, T-state encodings and bus status codes.
package bus_timing_pkg;

  localparam int INSTSIZE = 13;
  localparam int CYCBITS  = 4;

  localparam int GO6 = 0;
  localparam int DAD = 1;
  localparam int HLT = 2;
  localparam int DIO = 3;
  localparam int CYL = 4;
  localparam int CYH = 7;
  localparam int RWL = 8;
  localparam int RWH = 11;
  localparam int CCC = 12;

  localparam logic [2:0] TS_IDLE = 3'd0;
  localparam logic [2:0] TS_T1   = 3'd1;
  localparam logic [2:0] TS_T2   = 3'd2;
  localparam logic [2:0] TS_T3   = 3'd3;
  localparam logic [2:0] TS_T4   = 3'd4;
  localparam logic [2:0] TS_T5   = 3'd5;
  localparam logic [2:0] TS_T6   = 3'd6;
  localparam logic [2:0] TS_TW   = 3'd7;

  localparam logic [1:0] ST_HALT  = 2'b00;
  localparam logic [1:0] ST_WRITE = 2'b01;
  localparam logic [1:0] ST_READ  = 2'b10;
  localparam logic [1:0] ST_FETCH = 2'b11;

  typedef enum logic [3:0] {
    S_TRST, S_T1, S_T2, S_TW, S_T3, S_T4, S_T5, S_T6, S_THLT
  } state_t;

  // Bit n of a cycle field; positions past the field read as 0 (no M6).
  function automatic logic cyc_bit(input logic [CYCBITS-1:0] v, input logic [2:0] n);
    return (n < 3'd4) ? v[n[1:0]] : 1'b0;
  endfunction

endpackage

// File: rtl/bus_timing.sv
// 8085 machine-cycle and T-state sequencer: drives datapath strobes, bus control
// and status pins, READY wait states and halt from the latched instruction info.
module bus_timing
  import bus_timing_pkg::*;
(
  input  logic                clk,
  input  logic                rst_,
  input  logic [INSTSIZE-1:0] chk_i,
  input  logic                ready,
  output logic                enb_c,
  output logic                enb_d,
  output logic                enbpc,
  output logic                enb_r,
  output logic                enb_w,
  output logic                ale,
  output logic                rd_,
  output logic                wr_,
  output logic                io_m,
  output logic                s1,
  output logic                s0,
  output logic                hlta,
  output logic [2:0]          tstate,
  output logic [2:0]          mcyc,
  output logic                cc_ok
);

  state_t              state_q, state_d;
  logic [2:0]          mcyc_q, mcyc_d;
  logic [INSTSIZE-1:0] li_q, li_d;
  logic                pend_q, pend_d;
  logic                cc_q, cc_d;

  logic [CYCBITS-1:0]  li_go, li_rw, m1_go;
  logic                in_m1, dad_idle, mk_write, mk_rd, mk_iom, m1_hlt;
  logic [1:0]          st;
  logic                unused_li;

  assign li_go     = li_q[CYH:CYL];
  assign li_rw     = li_q[RWH:RWL];
  assign in_m1     = (mcyc_q == 3'd1);
  // DAD turns M2/M3 into internal cycles with no bus activity.
  assign dad_idle  = li_q[DAD] && (mcyc_q == 3'd2 || mcyc_q == 3'd3);
  assign mk_write  = !in_m1 && !dad_idle &&  cyc_bit(li_rw, mcyc_q - 3'd2);
  assign mk_rd     = !in_m1 && !dad_idle && !cyc_bit(li_rw, mcyc_q - 3'd2);
  assign mk_iom    = li_q[DIO] && (mcyc_q == 3'd3);
  // T4 decides from chk_i directly since li is only being loaded on that edge.
  assign m1_go     = (state_q == S_T4) ? chk_i[CYH:CYL] : li_go;
  assign m1_hlt    = (state_q == S_T4) ? chk_i[HLT] : li_q[HLT];
  assign unused_li = ^{li_q[GO6], li_q[CCC]};

  always_comb begin
    state_d = state_q;
    mcyc_d  = mcyc_q;
    li_d    = li_q;
    pend_d  = pend_q;
    cc_d    = cc_q;
    tstate  = TS_IDLE;
    st      = ST_HALT;
    enb_c   = 1'b0;
    enb_d   = 1'b0;
    enbpc   = 1'b0;
    enb_r   = 1'b0;
    enb_w   = 1'b0;
    ale     = 1'b0;
    rd_     = 1'b1;
    wr_     = 1'b1;
    io_m    = 1'b0;
    hlta    = 1'b0;
    case (state_q)
      S_TRST: begin
        state_d = S_T1;
        mcyc_d  = 3'd1;
      end
      S_T1: begin
        tstate  = TS_T1;
        state_d = S_T2;
        if (in_m1) begin
          st     = ST_FETCH;
          ale    = 1'b1;
          enb_w  = pend_q;
          pend_d = 1'b0;
        end else begin
          st    = mk_write ? ST_WRITE : ST_READ;
          ale   = !dad_idle;
          io_m  = mk_iom;
          enb_r = mk_write;
        end
      end
      S_T2, S_TW, S_T3: begin
        tstate = (state_q == S_T2) ? TS_T2 : (state_q == S_TW) ? TS_TW : TS_T3;
        if (in_m1) begin
          st  = ST_FETCH;
          rd_ = 1'b0;
        end else begin
          st   = mk_write ? ST_WRITE : ST_READ;
          io_m = mk_iom;
          rd_  = !mk_rd;
          wr_  = !mk_write;
        end
        if (state_q == S_T3) begin
          enb_c = in_m1;
          enb_d = mk_rd;
          if (in_m1) begin
            state_d = S_T4;
          end else if (!cyc_bit(li_go, mcyc_q - 3'd1)) begin
            state_d = S_T1;
            mcyc_d  = 3'd1;
            pend_d  = !mk_write;
          end else begin
            state_d = S_T1;
            mcyc_d  = mcyc_q + 3'd1;
          end
        end else begin
          enbpc   = (state_q == S_T2) && (in_m1 || mk_rd);
          state_d = (ready || dad_idle) ? S_T3 : S_TW;
        end
      end
      S_T4, S_T5, S_T6: begin
        st     = ST_FETCH;
        tstate = (state_q == S_T4) ? TS_T4 : (state_q == S_T5) ? TS_T5 : TS_T6;
        if (state_q == S_T4) begin
          li_d = chk_i;
          cc_d = chk_i[CCC];
        end
        if (state_q == S_T4 && chk_i[GO6]) begin
          state_d = S_T5;
        end else if (state_q == S_T5) begin
          state_d = S_T6;
        end else begin
          enb_w = (m1_go == '0) && !m1_hlt;
          if (m1_hlt) begin
            state_d = S_THLT;
          end else begin
            state_d = S_T1;
            mcyc_d  = (m1_go != '0) ? 3'd2 : 3'd1;
          end
        end
      end
      S_THLT: hlta = 1'b1;
      default: state_d = S_TRST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q <= S_TRST;
      mcyc_q  <= 3'd1;
      li_q    <= '0;
      pend_q  <= 1'b0;
      cc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mcyc_q  <= mcyc_d;
      li_q    <= li_d;
      pend_q  <= pend_d;
      cc_q    <= cc_d;
    end
  end

  assign {s1, s0} = st;
  assign mcyc     = mcyc_q;
  assign cc_ok    = cc_q;

endmodule

// File: tb/tb_bus_timing.sv
// Scoreboard bench for bus_timing: stimulus pushes hand-computed per-clock
// expectations, a negedge monitor pops and compares them against the pins.
module tb_bus_timing;
  import bus_timing_pkg::*;

  logic        clk = 1'b0;
  logic        rst_, ready;
  logic [12:0] chk_i;
  logic        enb_c, enb_d, enbpc, enb_r, enb_w, ale, rd_, wr_, io_m, s1, s0, hlta, cc_ok;
  logic [2:0]  tstate, mcyc;

  always #5 clk = ~clk;

  bus_timing dut (
    .clk(clk), .rst_(rst_), .chk_i(chk_i), .ready(ready),
    .enb_c(enb_c), .enb_d(enb_d), .enbpc(enbpc), .enb_r(enb_r), .enb_w(enb_w),
    .ale(ale), .rd_(rd_), .wr_(wr_), .io_m(io_m), .s1(s1), .s0(s0), .hlta(hlta),
    .tstate(tstate), .mcyc(mcyc), .cc_ok(cc_ok)
  );

  typedef struct packed {
    logic [2:0] ts;
    logic [2:0] mc;
    logic [1:0] st;
    logic [8:0] f;   // {ale, rd_, wr_, io_m, enb_c, enb_d, enbpc, enb_r, enb_w}
    logic       h;
    logic       cc;
  } exp_t;

  localparam logic [8:0] F_IDLE = 9'b011000000;
  localparam logic [8:0] F_A    = 9'b111000000;
  localparam logic [8:0] F_AW   = 9'b111000001;
  localparam logic [8:0] F_FT2  = 9'b001000100;
  localparam logic [8:0] F_RD   = 9'b001000000;
  localparam logic [8:0] F_FT3  = 9'b001010000;
  localparam logic [8:0] F_W    = 9'b011000001;
  localparam logic [8:0] F_RT3  = 9'b001001000;
  localparam logic [8:0] F_WT1  = 9'b111100010;
  localparam logic [8:0] F_WB   = 9'b010100000;

  exp_t        sb[$];
  string       nq[$];
  string       tname;
  logic [12:0] k;
  int          n_chk = 0;
  int          n_fail = 0;
  exp_t        e_m, a_m;
  string       n_m;

  function automatic exp_t ex(input logic [2:0] ts, input logic [2:0] mc, input logic [1:0] st,
                              input logic [8:0] f, input logic h, input logic cc);
    exp_t e;
    e.ts = ts; e.mc = mc; e.st = st; e.f = f; e.h = h; e.cc = cc;
    return e;
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e_m = sb.pop_front();
      n_m = nq.pop_front();
      a_m = ex(tstate, mcyc, {s1, s0}, {ale, rd_, wr_, io_m, enb_c, enb_d, enbpc, enb_r, enb_w},
               hlta, cc_ok);
      n_chk++;
      if (a_m !== e_m) begin
        n_fail++;
        $display("FAIL %s @%0t: got ts=%0d mc=%0d st=%b f=%b h=%b cc=%b, want ts=%0d mc=%0d st=%b f=%b h=%b cc=%b",
                 n_m, $time, a_m.ts, a_m.mc, a_m.st, a_m.f, a_m.h, a_m.cc,
                 e_m.ts, e_m.mc, e_m.st, e_m.f, e_m.h, e_m.cc);
      end
    end
  end

  task automatic step(input logic r, input logic rdy, input exp_t e);
    rst_  = r;
    chk_i = k;
    ready = rdy;
    @(posedge clk);
    #1;
    sb.push_back(e);
    nq.push_back(tname);
  endtask

  task automatic rs();
    step(1'b0, 1'b1, ex(3'd0, 3'd1, 2'b00, F_IDLE, 1'b0, 1'b0));
  endtask

  // M1 T1..T4; the new instruction word appears from T2 on.
  task automatic fetch(input logic [12:0] nk, input logic w1, input logic w4, input logic cc);
    step(1'b1, 1'b1, ex(3'd1, 3'd1, 2'b11, w1 ? F_AW : F_A, 1'b0, cc));
    k = nk;
    step(1'b1, 1'b1, ex(3'd2, 3'd1, 2'b11, F_FT2, 1'b0, cc));
    step(1'b1, 1'b1, ex(3'd3, 3'd1, 2'b11, F_FT3, 1'b0, cc));
    step(1'b1, 1'b1, ex(3'd4, 3'd1, 2'b11, w4 ? F_W : F_IDLE, 1'b0, cc));
  endtask

  task automatic rdcyc(input logic [2:0] mc, input logic cc);
    step(1'b1, 1'b1, ex(3'd1, mc, 2'b10, F_A, 1'b0, cc));
    step(1'b1, 1'b1, ex(3'd2, mc, 2'b10, F_FT2, 1'b0, cc));
    step(1'b1, 1'b1, ex(3'd3, mc, 2'b10, F_RT3, 1'b0, cc));
  endtask

  task automatic idlecyc(input logic [2:0] mc);
    step(1'b1, 1'b1, ex(3'd1, mc, 2'b10, F_IDLE, 1'b0, 1'b0));
    step(1'b1, 1'b1, ex(3'd2, mc, 2'b10, F_IDLE, 1'b0, 1'b0));
    step(1'b1, 1'b0, ex(3'd3, mc, 2'b10, F_IDLE, 1'b0, 1'b0));
  endtask

  initial begin
    k = 13'h000;
    tname = "reset";
    rs(); rs();

    tname = "mov";
    fetch(13'h000, 1'b0, 1'b1, 1'b0);
    fetch(13'h000, 1'b0, 1'b1, 1'b0);

    tname = "m1_wait";
    step(1'b1, 1'b1, ex(3'd1, 3'd1, 2'b11, F_A, 1'b0, 1'b0));
    step(1'b1, 1'b0, ex(3'd2, 3'd1, 2'b11, F_FT2, 1'b0, 1'b0));
    step(1'b1, 1'b0, ex(3'd7, 3'd1, 2'b11, F_RD, 1'b0, 1'b0));
    step(1'b1, 1'b0, ex(3'd7, 3'd1, 2'b11, F_RD, 1'b0, 1'b0));
    step(1'b1, 1'b1, ex(3'd3, 3'd1, 2'b11, F_FT3, 1'b0, 1'b0));
    step(1'b1, 1'b1, ex(3'd4, 3'd1, 2'b11, F_W, 1'b0, 1'b0));

    tname = "lda";
    fetch(13'h070, 1'b0, 1'b0, 1'b0);
    rdcyc(3'd2, 1'b0);
    rdcyc(3'd3, 1'b0);
    rdcyc(3'd4, 1'b0);
    fetch(13'h000, 1'b1, 1'b1, 1'b0);

    tname = "out";
    fetch(13'h238, 1'b0, 1'b0, 1'b0);
    rdcyc(3'd2, 1'b0);
    step(1'b1, 1'b1, ex(3'd1, 3'd3, 2'b01, F_WT1, 1'b0, 1'b0));
    step(1'b1, 1'b1, ex(3'd2, 3'd3, 2'b01, F_WB, 1'b0, 1'b0));
    step(1'b1, 1'b0, ex(3'd7, 3'd3, 2'b01, F_WB, 1'b0, 1'b0));
    step(1'b1, 1'b1, ex(3'd3, 3'd3, 2'b01, F_WB, 1'b0, 1'b0));
    fetch(13'h000, 1'b0, 1'b1, 1'b0);

    tname = "dad";
    fetch(13'h032, 1'b0, 1'b0, 1'b0);
    idlecyc(3'd2);
    idlecyc(3'd3);
    fetch(13'h000, 1'b1, 1'b1, 1'b0);

    tname = "go6_reset";
    fetch(13'h1031, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, ex(3'd5, 3'd1, 2'b11, F_IDLE, 1'b0, 1'b1));
    step(1'b1, 1'b1, ex(3'd6, 3'd1, 2'b11, F_IDLE, 1'b0, 1'b1));
    rdcyc(3'd2, 1'b1);
    step(1'b1, 1'b1, ex(3'd1, 3'd3, 2'b10, F_A, 1'b0, 1'b1));
    step(1'b1, 1'b1, ex(3'd2, 3'd3, 2'b10, F_FT2, 1'b0, 1'b1));
    step(1'b1, 1'b0, ex(3'd7, 3'd3, 2'b10, F_RD, 1'b0, 1'b1));
    rs();
    fetch(13'h001, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, ex(3'd5, 3'd1, 2'b11, F_IDLE, 1'b0, 1'b0));
    step(1'b1, 1'b1, ex(3'd6, 3'd1, 2'b11, F_W, 1'b0, 1'b0));

    tname = "hlt";
    fetch(13'h014, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, ex(3'd0, 3'd1, 2'b00, F_IDLE, 1'b1, 1'b0));
    step(1'b1, 1'b1, ex(3'd0, 3'd1, 2'b00, F_IDLE, 1'b1, 1'b0));
    step(1'b1, 1'b0, ex(3'd0, 3'd1, 2'b00, F_IDLE, 1'b1, 1'b0));
    rs();
    step(1'b1, 1'b1, ex(3'd1, 3'd1, 2'b11, F_A, 1'b0, 1'b0));

    repeat (3) @(posedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d expectations left, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
